ifu: RTL
========

IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000: address of the first fetch after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013: value held on inst while no fetched instruction has been captured.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port imem_req_valid, output, 1 bit: fetch request valid.
REQ-006 Port imem_req_ready, input, 1 bit: instruction memory accepts the request.
REQ-007 Port imem_req_addr, output, 32 bits: fetch address, equal to pc.
REQ-008 Port imem_rsp_valid, input, 1 bit: fetch data valid.
REQ-009 Port imem_rsp_data, input, 32 bits: fetched instruction word.
REQ-010 Port inst_valid, output, 1 bit: instruction presented to the decoder.
REQ-011 Port inst_ready, input, 1 bit: decoder/execute accepts inst.
REQ-012 Port inst, output, 32 bits: instruction word driven to the control generator.
REQ-013 Port pc, output, 32 bits: address of the current instruction.
REQ-014 Port commit_valid, input, 1 bit: one-cycle pulse, current instruction retired.
REQ-015 Port next_pc, input, 32 bits: next fetch address; sampled only with commit_valid.
REQ-016 Port fetch_err, output, 1 bit: sticky misaligned-PC error flag.
REQ-017 Port inst_cnt, output, 32 bits: count of retired instructions.

Function
REQ-018 The IFU SHALL implement a five-state FSM: REQ, WAIT_RSP, HOLD, WAIT_COMMIT, ERR.
REQ-019 REQ: imem_req_valid=1; on imem_req_ready=1 the FSM SHALL go to WAIT_RSP.
REQ-020 WAIT_RSP: on imem_rsp_valid=1, the IFU SHALL capture imem_rsp_data into inst and go to HOLD. A response in the same cycle as request acceptance is not possible; the earliest response arrives one cycle later.
REQ-021 HOLD: inst_valid=1; on inst_ready=1 the FSM SHALL go to WAIT_COMMIT; inst and pc SHALL stay stable while inst_valid=1.
REQ-022 WAIT_COMMIT: on commit_valid=1 the IFU SHALL load pc<=next_pc, increment inst_cnt by 1 and go to REQ. If next_pc[1:0]!=2'b00 it SHALL instead go to ERR and leave pc unchanged.
REQ-023 ERR: fetch_err=1, imem_req_valid=0, inst_valid=0; the FSM SHALL remain in ERR until rst.
REQ-024 imem_req_valid SHALL be 1 only in REQ; inst_valid SHALL be 1 only in HOLD.
REQ-025 imem_rsp_valid outside WAIT_RSP and commit_valid outside WAIT_COMMIT SHALL be ignored, with no state, pc or counter change.
REQ-026 inst SHALL keep its last captured value outside HOLD and SHALL not change on ignored responses.
REQ-027 inst_cnt SHALL wrap from 32'hFFFF_FFFF to 0 with no other effect.
REQ-028 next_pc arithmetic is outside this block; the IFU SHALL not add 4 itself.
REQ-029 A new request SHALL not be issued until the previous instruction commits: at most one instruction in flight.
REQ-030 Minimum fetch-to-next-fetch latency with zero-wait memory and an immediate decoder is 4 cycles: REQ, WAIT_RSP, HOLD, WAIT_COMMIT.

Reset
REQ-031 When rst=1 at a clock edge, the IFU SHALL set state=REQ, pc=RESET_PC, inst=NOP_INST, inst_cnt=0 and fetch_err=0, regardless of current state.
REQ-032 While rst=1: imem_req_valid=0, inst_valid=0.
REQ-033 Reset mid-transaction SHALL abandon any outstanding fetch; the instruction memory is reset by the same rst, so no stale response follows.
REQ-034 The first request SHALL be issued in the first cycle after rst deasserts.

Verification
REQ-035 Reset then zero-wait memory returns 32'h0010_0093, decoder ready, commit with next_pc=32'h8000_0004 -> inst=32'h0010_0093 with pc=32'h8000_0000 for one HOLD cycle; next imem_req_addr=32'h8000_0004; inst_cnt=1.
REQ-036 imem_req_ready held low 5 cycles, imem_rsp_valid delayed 3 cycles -> imem_req_valid stays 1 throughout; inst_valid rises only the cycle after the response; pc stable.
REQ-037 inst_ready low 4 cycles in HOLD -> inst_valid, inst and pc held unchanged; spurious commit_valid in HOLD ignored; inst_cnt unchanged.
REQ-038 Commit with next_pc=32'h8000_0102 -> state ERR, fetch_err=1, pc stays at old value, no further requests; rst clears fetch_err and the next request goes to 32'h8000_0000.
REQ-039 rst asserted in WAIT_RSP, then imem_rsp_valid pulsed after the next request is accepted -> pc=32'h8000_0000, inst=32'h0000_0013 until the new response is captured.
REQ-040 Preload inst_cnt path to 32'hFFFF_FFFF via repeated commits (or force), one more commit -> inst_cnt=0, fetch continues normally.

Source files
------------

// File: rtl/ifu.sv
// Instruction fetch unit: one instruction in flight at a time.
// It requests a word at pc, waits for the response, and presents it to the decoder.
// It then waits for the retire pulse and loads the next fetch address supplied by the core.
// A misaligned next address parks the unit in a sticky error state until reset.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        commit_valid,
    input  logic [31:0] next_pc,
    output logic        fetch_err,
    output logic [31:0] inst_cnt
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT_RSP,
        S_HOLD,
        S_WAIT_COMMIT,
        S_ERR
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_capture;
    logic        w_commit_ok;
    logic        w_commit_bad;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_inst_cnt;
    logic        r_fetch_err;

    // Next-state decode; inputs that do not belong to the current state are ignored.
    always_comb begin
        w_state_nxt  = r_state;
        w_capture    = 1'b0;
        w_commit_ok  = 1'b0;
        w_commit_bad = 1'b0;
        case (r_state)
            S_REQ: begin
                if (imem_req_ready) w_state_nxt = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (imem_rsp_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready) w_state_nxt = S_WAIT_COMMIT;
            end
            S_WAIT_COMMIT: begin
                if (commit_valid) begin
                    if (next_pc[1:0] == 2'b00) begin
                        w_commit_ok = 1'b1;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_commit_bad = 1'b1;
                        w_state_nxt  = S_ERR;
                    end
                end
            end
            S_ERR: begin
                w_state_nxt = S_ERR;
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    // State register; reset abandons any outstanding fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // pc, captured instruction, retire counter and sticky error flag.
    // A misaligned commit is rejected whole: pc and the counter are left alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_inst      <= NOP_INST;
            r_inst_cnt  <= 32'd0;
            r_fetch_err <= 1'b0;
        end else begin
            if (w_capture) r_inst <= imem_rsp_data;
            if (w_commit_ok) begin
                r_pc       <= next_pc;
                r_inst_cnt <= r_inst_cnt + 32'd1;
            end
            if (w_commit_bad) r_fetch_err <= 1'b1;
        end
    end

    assign imem_req_valid = (r_state == S_REQ) && !rst;
    assign inst_valid     = (r_state == S_HOLD) && !rst;
    assign imem_req_addr  = r_pc;
    assign pc             = r_pc;
    assign inst           = r_inst;
    assign inst_cnt       = r_inst_cnt;
    assign fetch_err      = r_fetch_err;

endmodule
